control_sequencer: RTL and testbench

Parametrised successor to the pipeline control decoder. It owns the decode-stage control FSM for multi-word instructions: a head word followed by 0..MAX_EXT extension words. It also applies stall/flush bubbles and emits the REG/EX/MEM/WB control bundles consumed by the pipeline registers. Opcode decoding lives in a combinational sub-module. This block adds the sequencing, the head-word latching and the side-effect gating.

---
 rtl/control_pkg.sv | 52 +++++
 rtl/control_decode.sv | 41 ++++
 rtl/control_sequencer.sv | 107 ++++++++++
 tb/tb_control_sequencer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// control_pkg: opcodes, ALU ops, bundle layouts and extension-length rule shared by the decode stage
package control_pkg;
   localparam logic [4:0] OP_RTYPE   = 5'b00000;
   localparam logic [4:0] OP_ADDI    = 5'b00001;
   localparam logic [4:0] OP_ANDI    = 5'b00010;
   localparam logic [4:0] OP_LW      = 5'b00011;
   localparam logic [4:0] OP_SWN     = 5'b00100;
   localparam logic [4:0] OP_BEQ     = 5'b00101;
   localparam logic [4:0] OP_BNE     = 5'b00110;
   localparam logic [4:0] OP_J       = 5'b00111;
   localparam logic [4:0] OP_JAL     = 5'b01000;
   localparam logic [4:0] OP_JR      = 5'b01001;
   localparam logic [4:0] OP_LDX     = 5'b01010;
   localparam logic [4:0] OP_LDI     = 5'b01011;
   localparam logic [4:0] OP_LDL     = 5'b01100;
   localparam logic [4:0] OP_SYSCALL = 5'b01101;
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_CMP = 3'b111;
   localparam int REG_ISJ       = 0;
   localparam int REG_EXTACTIVE = 1;
   localparam int EX_ISJR       = 6;
   localparam int MEM_MEMWRITE  = 3;
   localparam int MEM_ISBRANCH  = 6;
   localparam int WB_REGWRITE   = 0;
   typedef struct packed {
      logic [4:0] zero;
      logic       is_jr;
      logic [2:0] alu_op;
      logic [1:0] alu_src_b;
      logic       alu_src_a;
   } ex_t;
   typedef struct packed {
      logic       wide32;
      logic       sign_ext16;
      logic       is_branch;
      logic [1:0] branch_type;
      logic       mem_write;
      logic [2:0] result_src;
   } mem_t;
   typedef struct packed {
      logic       zero;
      logic       display_write;
      logic [1:0] reg_write_target;
      logic       reg_write;
   } wb_t;
   function automatic int ext_len(input logic [4:0] op, input int max_ext);
      return (op == OP_LDI || op == OP_LDL) ? 1 : (op == OP_LDX) ? max_ext : 0;
   endfunction
endpackage

// File: rtl/control_decode.sv
// control_decode: combinational OpCode/FuncCode to raw EX/MEM/WB bundles plus jump flag
// ports: OpCode, FuncCode in; ex, mem, wb bundles and is_j out
module control_decode import control_pkg::*; #(
   parameter int OPW   = 5,
   parameter int FUNCW = 3
) (
   input  logic [OPW-1:0]   OpCode,
   input  logic [FUNCW-1:0] FuncCode,
   output ex_t              ex,
   output mem_t             mem,
   output wb_t              wb,
   output logic             is_j
);
   always_comb begin
      ex = '0;
      mem = '0;
      wb = '0;
      is_j = 1'b0;
      case (OpCode)
         OPW'(OP_RTYPE): begin wb.reg_write = 1'b1; ex.alu_op = 3'(FuncCode); end
         OPW'(OP_ADDI): begin wb.reg_write = 1'b1; wb.reg_write_target = 2'b01; ex.alu_src_b = 2'b01; ex.alu_op = ALU_ADD; mem.sign_ext16 = 1'b1; end
         OPW'(OP_ANDI): begin wb.reg_write = 1'b1; wb.reg_write_target = 2'b01; ex.alu_src_b = 2'b10; ex.alu_op = ALU_AND; end
         OPW'(OP_LW): begin wb.reg_write = 1'b1; wb.reg_write_target = 2'b01; ex.alu_src_b = 2'b01; ex.alu_op = ALU_ADD; mem.result_src = 3'b001; mem.sign_ext16 = 1'b1; end
         OPW'(OP_SWN): begin mem.mem_write = 1'b1; ex.alu_src_b = 2'b01; ex.alu_op = ALU_ADD; mem.sign_ext16 = 1'b1; end
         OPW'(OP_BEQ): begin mem.is_branch = 1'b1; mem.branch_type = 2'b00; ex.alu_op = ALU_CMP; end
         OPW'(OP_BNE): begin mem.is_branch = 1'b1; mem.branch_type = 2'b01; ex.alu_op = ALU_CMP; end
         OPW'(OP_J): is_j = 1'b1;
         OPW'(OP_JAL): begin is_j = 1'b1; wb.reg_write = 1'b1; wb.reg_write_target = 2'b10; mem.result_src = 3'b011; end
         OPW'(OP_JR): begin ex.is_jr = 1'b1; ex.alu_src_a = 1'b1; end
         OPW'(OP_LDX): begin wb.reg_write = 1'b1; wb.reg_write_target = 2'b01; mem.result_src = 3'b100; mem.wide32 = 1'b1; end
         OPW'(OP_LDI): begin wb.reg_write = 1'b1; wb.reg_write_target = 2'b01; mem.result_src = 3'b010; mem.sign_ext16 = 1'b1; end
         OPW'(OP_LDL): begin wb.reg_write = 1'b1; wb.reg_write_target = 2'b01; mem.result_src = 3'b010; mem.wide32 = 1'b1; end
         OPW'(OP_SYSCALL): begin
            wb.display_write = 1'b1;
            wb.reg_write = FuncCode[0];
            wb.reg_write_target = {2{FuncCode[0]}};
         end
         default: ;
      endcase
   end
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: decode-stage FSM for head + extension-word instructions with bubble gating
// ports: clk, Reset (sync, active-low), OpCode, FuncCode, InstValid, Stall, Flush in;
//        REG, EX, MEM, WB control bundles, ExtIndex, LastExt out
module control_sequencer import control_pkg::*; #(
   parameter int OPW     = 5,
   parameter int FUNCW   = 3,
   parameter int MAX_EXT = 3,
   parameter int CNTW    = $clog2(MAX_EXT + 1)
) (
   input  logic             clk,
   input  logic             Reset,
   input  logic [OPW-1:0]   OpCode,
   input  logic [FUNCW-1:0] FuncCode,
   input  logic             InstValid,
   input  logic             Stall,
   input  logic             Flush,
   output logic [1:0]       REG,
   output logic [11:0]      EX,
   output logic [8:0]       MEM,
   output logic [4:0]       WB,
   output logic [CNTW-1:0]  ExtIndex,
   output logic             LastExt
);
   ex_t dec_ex;
   mem_t dec_mem;
   wb_t dec_wb;
   logic dec_j;
   logic [CNTW-1:0] ext_remain, ext_len_q, head_len;
   logic [11:0] head_ex;
   logic [8:0] head_mem;
   logic [4:0] head_wb;
   logic consume, ext_active, ext_last;
   control_decode #(.OPW(OPW), .FUNCW(FUNCW)) u_decode (
      .OpCode(OpCode),
      .FuncCode(FuncCode),
      .ex(dec_ex),
      .mem(dec_mem),
      .wb(dec_wb),
      .is_j(dec_j)
   );
   assign consume = InstValid & ~Stall & ~Flush;
   assign ext_active = ext_remain != '0;
   assign ext_last = ext_remain == CNTW'(1);
   assign head_len = CNTW'(ext_len(5'(OpCode), MAX_EXT));
   always_ff @(posedge clk) begin
      if (!Reset) begin
         ext_remain <= '0;
         ext_len_q <= '0;
         head_ex <= '0;
         head_mem <= '0;
         head_wb <= '0;
      end else if (Flush) begin
         ext_remain <= '0;
         head_ex <= '0;
         head_mem <= '0;
         head_wb <= '0;
      end else if (consume) begin
         if (ext_active) ext_remain <= ext_remain - CNTW'(1);
         else if (head_len != '0) begin
            ext_remain <= head_len;
            ext_len_q <= head_len;
            head_ex <= dec_ex;
            head_mem <= dec_mem;
            head_wb <= dec_wb;
         end
      end
   end
   always_comb begin
      EX = dec_ex;
      MEM = dec_mem;
      WB = dec_wb;
      REG = {1'b0, dec_j};
      ExtIndex = '0;
      LastExt = 1'b0;
      if (ext_active) begin
         // extension words carry raw data; only the final one replays the latched head with its deferred write
         REG = '0;
         REG[REG_EXTACTIVE] = 1'b1;
         ExtIndex = ext_len_q - ext_remain + CNTW'(1);
         LastExt = ext_last;
         EX = ext_last ? head_ex : '0;
         MEM = ext_last ? head_mem : '0;
         WB = ext_last ? head_wb : '0;
         WB[WB_REGWRITE] = ext_last;
      end else if (head_len != '0) begin
         WB[WB_REGWRITE] = 1'b0;
         MEM[MEM_MEMWRITE] = 1'b0;
         EX[EX_ISJR] = 1'b0;
         REG[REG_ISJ] = 1'b0;
      end
      if (!consume) begin
         WB[WB_REGWRITE] = 1'b0;
         MEM[MEM_MEMWRITE] = 1'b0;
         MEM[MEM_ISBRANCH] = 1'b0;
         EX[EX_ISJR] = 1'b0;
         REG[REG_ISJ] = 1'b0;
      end
      if (!Reset) begin
         EX = '0;
         MEM = '0;
         WB = '0;
         REG = '0;
         ExtIndex = '0;
         LastExt = 1'b0;
      end
   end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: directed stimulus with an instruction-level reference model and literal spot checks
module tb_control_sequencer;
   localparam int MAX_EXT = 3;
   localparam logic [4:0] RTYPE = 5'd0, ADDI = 5'd1, ANDI = 5'd2, LW = 5'd3, SWN = 5'd4, BEQ = 5'd5, BNE = 5'd6;
   localparam logic [4:0] JMP = 5'd7, JAL = 5'd8, JR = 5'd9, LDX = 5'b01010, LDI = 5'd11, LDL = 5'd12, SYSC = 5'd13;
   logic clk = 1'b0, Reset = 1'b0;
   logic [4:0] OpCode = '0;
   logic [2:0] FuncCode = '0;
   logic InstValid = 1'b0, Stall = 1'b0, Flush = 1'b0;
   logic [1:0] REG;
   logic [11:0] EX;
   logic [8:0] MEM;
   logic [4:0] WB;
   logic [1:0] ExtIndex;
   logic LastExt;
   int pass_cnt = 0, total_cnt = 0;
   int m_left = 0, m_total = 0;
   logic [25:0] m_head = '0;
   always #5 clk = ~clk;
   control_sequencer #(.MAX_EXT(MAX_EXT)) dut (
      .clk(clk), .Reset(Reset), .OpCode(OpCode), .FuncCode(FuncCode),
      .InstValid(InstValid), .Stall(Stall), .Flush(Flush),
      .REG(REG), .EX(EX), .MEM(MEM), .WB(WB), .ExtIndex(ExtIndex), .LastExt(LastExt)
   );
   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h at %0t", n, got, exp, $time);
   endtask
   // {IsJOrJAL, EX[11:0], MEM[8:0], WB[4:0]} from named fields
   function automatic logic [26:0] f(input int j, srca, srcb, aop, jr, rs, mw, bt, br, se, w32, rw, tgt, dw);
      return {1'(j), 5'd0, 1'(jr), 3'(aop), 2'(srcb), 1'(srca), 1'(w32), 1'(se), 1'(br), 2'(bt), 1'(mw), 3'(rs), 1'b0, 1'(dw), 2'(tgt), 1'(rw)};
   endfunction
   function automatic logic [26:0] ref_dec(input logic [4:0] op, input logic [2:0] fc);
      case (op)
         //             j a b aop     jr rs mw bt br se w  rw tgt dw
         RTYPE: return f(0,0,0,int'(fc),0,0,0,0,0,0,0,1,0,0);
         ADDI:  return f(0,0,1,0,0,0,0,0,0,1,0,1,1,0);
         ANDI:  return f(0,0,2,2,0,0,0,0,0,0,0,1,1,0);
         LW:    return f(0,0,1,0,0,1,0,0,0,1,0,1,1,0);
         SWN:   return f(0,0,1,0,0,0,1,0,0,1,0,0,0,0);
         BEQ:   return f(0,0,0,7,0,0,0,0,1,0,0,0,0,0);
         BNE:   return f(0,0,0,7,0,0,0,1,1,0,0,0,0,0);
         JMP:   return f(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
         JAL:   return f(1,0,0,0,0,3,0,0,0,0,0,1,2,0);
         JR:    return f(0,1,0,0,1,0,0,0,0,0,0,0,0,0);
         LDX:   return f(0,0,0,0,0,4,0,0,0,0,1,1,1,0);
         LDI:   return f(0,0,0,0,0,2,0,0,0,1,0,1,1,0);
         LDL:   return f(0,0,0,0,0,2,0,0,0,0,1,1,1,0);
         SYSC:  return f(0,0,0,0,0,0,0,0,0,0,0,int'(fc[0]),fc[0] ? 3 : 0,1);
         default: return '0;
      endcase
   endfunction
   function automatic int ref_len(input logic [4:0] op);
      return (op == LDI || op == LDL) ? 1 : (op == LDX) ? MAX_EXT : 0;
   endfunction
   always @(posedge clk) begin
      if (!Reset) begin
         m_left <= 0;
         m_total <= 0;
         m_head <= '0;
      end else if (Flush) begin
         m_left <= 0;
         m_head <= '0;
      end else if (InstValid && !Stall) begin
         if (m_left > 0) m_left <= m_left - 1;
         else if (ref_len(OpCode) > 0) begin
            m_left <= ref_len(OpCode);
            m_total <= ref_len(OpCode);
            m_head <= 26'(ref_dec(OpCode, FuncCode));
         end
      end
   end
   always @(negedge clk) begin : compare
      logic [1:0] r;
      logic [11:0] e;
      logic [8:0] m;
      logic [4:0] w;
      logic [1:0] ix;
      logic lx;
      logic [26:0] d;
      d = ref_dec(OpCode, FuncCode);
      {r, e, m, w, ix, lx} = '0;
      if (Reset) begin
         if (m_left > 0) begin
            r = 2'b10;
            ix = 2'(m_total - m_left + 1);
            lx = m_left == 1;
            if (m_left == 1) begin
               {e, m, w} = m_head;
               w[0] = 1'b1;
            end
         end else begin
            r = {1'b0, d[26]};
            {e, m, w} = d[25:0];
            if (ref_len(OpCode) > 0) begin r[0] = 0; w[0] = 0; m[3] = 0; e[6] = 0; end
         end
         if (!InstValid || Stall || Flush) begin r[0] = 0; w[0] = 0; m[3] = 0; m[6] = 0; e[6] = 0; end
      end
      chk("REG", REG, r);
      chk("EX", EX, e);
      chk("MEM", MEM, m);
      chk("WB", WB, w);
      chk("ExtIndex", ExtIndex, ix);
      chk("LastExt", LastExt, lx);
   end
   task automatic step(input logic rst, input logic [4:0] op, input logic [2:0] fc, input logic v, input logic s, input logic fl);
      @(posedge clk);
      #1;
      Reset = rst; OpCode = op; FuncCode = fc; InstValid = v; Stall = s; Flush = fl;
      @(negedge clk);
      #1;
   endtask
   initial begin
      step(0, ADDI, 0, 1, 0, 0);
      step(0, ADDI, 0, 1, 0, 0);
      chk("rst_all", {REG, EX, MEM, WB, ExtIndex, LastExt}, 0);
      step(1, ADDI, 0, 1, 0, 0);
      chk("addi_rw", WB[0], 1); chk("addi_tgt", WB[2:1], 2'b01); chk("addi_srcb", EX[2:1], 2'b01);
      step(1, LDI, 0, 1, 0, 0);
      chk("ldi_head_rw", WB[0], 0); chk("ldi_head_idx", ExtIndex, 0); chk("ldi_head_act", REG[1], 0);
      step(1, JAL, 7, 1, 0, 0);
      chk("ldi_ext_act", REG[1], 1); chk("ldi_ext_idx", ExtIndex, 1); chk("ldi_ext_last", LastExt, 1);
      chk("ldi_ext_rw", WB[0], 1); chk("ldi_ext_rs", MEM[2:0], 3'b010); chk("ldi_ext_se", MEM[7], 1);
      step(1, LDX, 0, 1, 0, 0); chk("ldx_i0", ExtIndex, 0); chk("ldx_rw0", WB[0], 0);
      step(1, JAL, 1, 1, 0, 0); chk("ldx_i1", ExtIndex, 1); chk("ldx_rw1", WB[0], 0); chk("ldx_j1", REG[0], 0);
      step(1, SWN, 0, 1, 1, 0); chk("ldx_i2s", ExtIndex, 2); chk("ldx_mw_stall", MEM[3], 0);
      step(1, SWN, 0, 1, 0, 0); chk("ldx_i2", ExtIndex, 2); chk("ldx_rw2", WB[0], 0);
      step(1, RTYPE, 0, 1, 1, 0); chk("ldx_i3s", ExtIndex, 3); chk("ldx_rw3s", WB[0], 0); chk("ldx_last_s", LastExt, 1);
      step(1, RTYPE, 0, 1, 0, 0); chk("ldx_i3", ExtIndex, 3); chk("ldx_rw3", WB[0], 1); chk("ldx_w32", MEM[8], 1);
      step(1, LDX, 0, 1, 0, 0);
      step(1, RTYPE, 0, 1, 0, 0);
      step(1, RTYPE, 0, 1, 0, 1); chk("flush_i2", ExtIndex, 2); chk("flush_rw", WB[0], 0);
      step(1, ADDI, 0, 1, 0, 0); chk("post_flush_act", REG[1], 0); chk("post_flush_rw", WB[0], 1);
      step(1, SWN, 0, 1, 1, 0); chk("swn_stall_mw", MEM[3], 0);
      step(1, SWN, 0, 1, 0, 0); chk("swn_mw", MEM[3], 1); chk("swn_aluop", EX[5:3], 0);
      step(1, BNE, 0, 1, 0, 0); chk("bne_br", MEM[6], 1); chk("bne_bt", MEM[5:4], 2'b01); chk("bne_aluop", EX[5:3], 3'b111);
      step(1, BNE, 0, 0, 0, 0); chk("bne_inv_br", MEM[6], 0);
      step(1, LDL, 0, 1, 0, 0);
      step(1, RTYPE, 0, 1, 0, 1); chk("flush_last_rw", WB[0], 0);
      step(1, ADDI, 0, 1, 0, 0); chk("flush_last_idle", REG[1], 0);
      step(1, LDX, 0, 1, 0, 1);
      step(1, ADDI, 0, 1, 0, 0); chk("flush_head_idle", REG[1], 0); chk("flush_head_rw", WB[0], 1);
      step(1, LDI, 0, 1, 0, 0);
      step(1, RTYPE, 0, 0, 0, 0); chk("inv_hold_idx", ExtIndex, 1); chk("inv_hold_rw", WB[0], 0);
      step(1, RTYPE, 0, 1, 1, 1); chk("flush_stall_rw", WB[0], 0);
      step(1, ADDI, 0, 1, 0, 0); chk("flush_stall_idle", REG[1], 0);
      step(1, LDX, 0, 1, 0, 0);
      step(1, RTYPE, 0, 1, 0, 0);
      step(0, RTYPE, 0, 1, 0, 0); chk("rst_mid_all", {REG, EX, MEM, WB, ExtIndex, LastExt}, 0);
      step(1, RTYPE, 5, 1, 0, 0); chk("rst_mid_idle", REG[1], 0); chk("rtype_aluop", EX[5:3], 5);
      step(1, SYSC, 1, 1, 0, 0); chk("sys1_rw", WB[0], 1); chk("sys1_dw", WB[3], 1);
      step(1, SYSC, 0, 1, 0, 0); chk("sys0_rw", WB[0], 0); chk("sys0_tgt", WB[2:1], 0);
      step(1, JAL, 0, 1, 0, 0); chk("jal_j", REG[0], 1);
      step(1, JMP, 0, 1, 1, 0); chk("j_stall", REG[0], 0);
      step(1, JR, 0, 1, 0, 0); chk("jr", EX[6], 1);
      step(1, ANDI, 0, 1, 0, 0);
      step(1, LW, 0, 1, 0, 0);
      step(1, BEQ, 0, 1, 0, 0);
      step(1, 5'b11111, 7, 1, 0, 0); chk("unknown", {REG, EX, MEM, WB}, 0);
      step(1, LDL, 0, 1, 0, 0);
      step(1, LDI, 0, 1, 1, 0);
      step(1, LDI, 0, 1, 0, 0); chk("ldl_last_rw", WB[0], 1); chk("ldl_w32", MEM[8], 1);
      step(1, ADDI, 0, 0, 0, 0);
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
